tdm_demux_1x2: RTL and testbench
================================

# tdm_demux_1x2

Two-channel time-division demultiplexer: accepts one interleaved sample stream (channel 0, channel 1, channel 0, ...) framed by a start-of-frame marker and steers each sample into one of two registered output channels with per-channel valid pulses. It sits at the receive end of the team's two-channel TDM link, undoing the 2:1 selection done at the transmit end. It tracks frame alignment, drops misaligned samples, recovers on the next marker and counts framing (and optionally parity) errors.

## Interface
- WIDTH, 8, sample width in bits
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  WIDTH  incoming sample
- din_valid  input  1  din (and sof) valid this cycle; no backpressure
- sof  input  1  marks the channel-0 sample of a frame; ignored when din_valid=0
- x0  output  WIDTH  last accepted channel-0 sample, held between updates
- x1  output  WIDTH  last accepted channel-1 sample, held between updates
- x0_valid  output  1  one-cycle pulse when x0 updates
- x1_valid  output  1  one-cycle pulse when x1 updates
- sync  output  1  high while frame-aligned (state EXP0 or EXP1)
- err_cnt  output  8  saturating error count

## Operation
- States: HUNT (unaligned), EXP1 (channel-1 sample expected), EXP0 (channel-0 sample expected).
- Only cycles with din_valid=1 are considered; din_valid=0 holds all state, valids low.
- HUNT: sof=1 -> capture x0, pulse x0_valid, go EXP1. sof=0 -> discard, stay HUNT, no error.
- EXP1: sof=0 -> capture x1, pulse x1_valid, go EXP0. sof=1 (short frame) -> treat as new frame: capture x0, pulse x0_valid, stay EXP1, err_cnt+1.
- EXP0: sof=1 -> capture x0, pulse x0_valid, go EXP1. sof=0 (lost alignment) -> discard, go HUNT, err_cnt+1.
- err_cnt saturates at 255; cleared only by rst.
- At most one of x0_valid/x1_valid high in any cycle.
- sync is a registered decode of state: 1 in EXP0/EXP1, 0 in HUNT.

## Timing
- Latency 1 cycle: sample on din at edge N appears on x0/x1 with its valid pulse after edge N, i.e. valid during cycle N+1.
- Back-to-back din_valid every cycle sustained: one sample accepted per clock.
- Reset (async assert, any time incl. mid-frame): state HUNT; x0=0, x1=0, x0_valid=0, x1_valid=0, sync=0, err_cnt=0. First edge after deassertion already evaluates inputs.
- err_cnt increments in the same edge as the offending sample; at 255 further errors leave it 255.
- Outputs not updated hold their value indefinitely.

## Configuration
- TDM_DEMUX_PARITY_EN defined: extra input din_par (1 bit, qualified by din_valid); even parity over {din, din_par} required. On mismatch: x0/x1 not written, no valid pulse, err_cnt+1 (once, even if a framing error coincides); state transitions proceed as if the sample were good, except in HUNT a bad-parity sof keeps HUNT.
- Not defined: no din_par port, no parity check; behaviour exactly as Operation.

## Test plan
- Reset then stream sof=1 din=0x11, sof=0 din=0x22, sof=1 0x33, sof=0 0x44 every cycle -> x0=0x11/x0_valid, next cycle x1=0x22/x1_valid, then 0x33, 0x44; sync=1 from first accepted sample; err_cnt=0.
- Stream without sof (0xAA, 0xBB) after reset -> no valids, sync=0, err_cnt=0; then sof 0x01 -> x0=0x01, sync=1.
- Aligned, then in EXP0 send sof=0 0x55 -> discarded, sync drops, err_cnt=1; next sof=1 0x66 -> x0=0x66, resync.
- In EXP1 send sof=1 0x77 -> x0=0x77, x0_valid, x1 unchanged, err_cnt+1, next sof=0 0x88 -> x1=0x88.
- Insert din_valid=0 gaps between samples -> identical outputs to gapless run, valids only after valid samples; assert rst mid-frame -> all outputs 0 immediately; force 300 errors -> err_cnt=255.
- With TDM_DEMUX_PARITY_EN: good frame then channel-1 sample with wrong din_par -> x1 held, no x1_valid, err_cnt+1, next sof accepted normally.

Source files
------------

// File: rtl/tdm_demux_1x2_if.sv
// Sample-in / channel-out bundle for the two-channel TDM demultiplexer.
// Optional din_par exists only when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux_1x2_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sof;
`ifdef TDM_DEMUX_PARITY_EN
    logic             din_par;
`endif
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] x1;
    logic             x0_valid;
    logic             x1_valid;
    logic             sync;
    logic [7:0]       err_cnt;

    modport master (
        output din, din_valid, sof,
`ifdef TDM_DEMUX_PARITY_EN
        output din_par,
`endif
        input  x0, x1, x0_valid, x1_valid, sync, err_cnt
    );

    modport slave (
        input  din, din_valid, sof,
`ifdef TDM_DEMUX_PARITY_EN
        input  din_par,
`endif
        output x0, x1, x0_valid, x1_valid, sync, err_cnt
    );
endinterface

// File: rtl/tdm_demux_1x2.sv
// 1:2 TDM demux with frame tracking; 1-cycle latency, no backpressure.
// Optional even-parity check on din enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux_1x2 #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    tdm_demux_1x2_if.slave  bus
);
    typedef enum logic [1:0] {HUNT, EXP1, EXP0} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x0_q, x0_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic             x0_valid_q, x0_valid_d;
    logic             x1_valid_q, x1_valid_d;
    logic             sync_q;
    logic [7:0]       err_q, err_d;
    logic             err_inc;
    logic             par_ok;

`ifdef TDM_DEMUX_PARITY_EN
    assign par_ok = ~^{bus.din, bus.din_par};
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        x0_valid_d = 1'b0;
        x1_valid_d = 1'b0;
        err_inc    = 1'b0;
        if (bus.din_valid) begin
            // A parity error is counted once even if a framing error coincides.
            err_inc = ~par_ok;
            case (state_q)
                HUNT: begin
                    if (bus.sof && par_ok) begin
                        x0_d       = bus.din;
                        x0_valid_d = 1'b1;
                        state_d    = EXP1;
                    end
                end
                EXP1: begin
                    if (bus.sof) begin
                        err_inc = 1'b1;
                        if (par_ok) begin
                            x0_d       = bus.din;
                            x0_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = EXP0;
                        if (par_ok) begin
                            x1_d       = bus.din;
                            x1_valid_d = 1'b1;
                        end
                    end
                end
                EXP0: begin
                    if (bus.sof) begin
                        state_d = EXP1;
                        if (par_ok) begin
                            x0_d       = bus.din;
                            x0_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = HUNT;
                        err_inc = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            x0_q       <= '0;
            x1_q       <= '0;
            x0_valid_q <= 1'b0;
            x1_valid_q <= 1'b0;
            sync_q     <= 1'b0;
            err_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            x0_valid_q <= x0_valid_d;
            x1_valid_q <= x1_valid_d;
            sync_q     <= (state_d != HUNT);
            err_q      <= err_d;
        end
    end

    assign bus.x0       = x0_q;
    assign bus.x1       = x1_q;
    assign bus.x0_valid = x0_valid_q;
    assign bus.x1_valid = x1_valid_q;
    assign bus.sync     = sync_q;
    assign bus.err_cnt  = err_q;
endmodule

// File: tb/tb_tdm_demux_1x2.sv
// Directed bench for tdm_demux_1x2: framing, resync, gaps, reset, saturation.
// Parity scenario compiles in only when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux_1x2;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    tdm_demux_1x2_if #(.WIDTH(8)) bus ();
    tdm_demux_1x2 #(.WIDTH(8)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Drive one cycle of input at the falling edge; return 1 time unit after the rising edge.
    task automatic send(input logic v, input logic s, input logic [7:0] d, input logic bad_par = 1'b0);
        @(negedge clk);
        bus.din_valid = v;
        bus.sof       = s;
        bus.din       = d;
`ifdef TDM_DEMUX_PARITY_EN
        bus.din_par   = (^d) ^ bad_par;
`else
        if (bad_par) $display("note: parity not built in");
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.din_valid = 1'b0;
        bus.sof = 1'b0;
        bus.din = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.din_valid = 1'b0;
        bus.sof = 1'b0;
        bus.din = 8'h00;
`ifdef TDM_DEMUX_PARITY_EN
        bus.din_par = 1'b0;
`endif
        #12;
        chk_cnt++; if (bus.x0 !== 8'h00) $display("FAIL rst_x0 got %h exp 00", bus.x0); else pass_cnt++;
        chk_cnt++; if (bus.x1 !== 8'h00) $display("FAIL rst_x1 got %h exp 00", bus.x1); else pass_cnt++;
        chk_cnt++; if (bus.x0_valid !== 1'b0) $display("FAIL rst_x0v got %b exp 0", bus.x0_valid); else pass_cnt++;
        chk_cnt++; if (bus.x1_valid !== 1'b0) $display("FAIL rst_x1v got %b exp 0", bus.x1_valid); else pass_cnt++;
        chk_cnt++; if (bus.sync !== 1'b0) $display("FAIL rst_sync got %b exp 0", bus.sync); else pass_cnt++;
        chk_cnt++; if (bus.err_cnt !== 8'd0) $display("FAIL rst_err got %0d exp 0", bus.err_cnt); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        send(1, 1, 8'h11);
        chk_cnt++; if (bus.x0 !== 8'h11) $display("FAIL st_x0_11 got %h exp 11", bus.x0); else pass_cnt++;
        chk_cnt++; if (bus.x0_valid !== 1'b1) $display("FAIL st_x0v_1 got %b exp 1", bus.x0_valid); else pass_cnt++;
        chk_cnt++; if (bus.x1_valid !== 1'b0) $display("FAIL st_x1v_1 got %b exp 0", bus.x1_valid); else pass_cnt++;
        chk_cnt++; if (bus.sync !== 1'b1) $display("FAIL st_sync_1 got %b exp 1", bus.sync); else pass_cnt++;
        send(1, 0, 8'h22);
        chk_cnt++; if (bus.x1 !== 8'h22) $display("FAIL st_x1_22 got %h exp 22", bus.x1); else pass_cnt++;
        chk_cnt++; if (bus.x1_valid !== 1'b1) $display("FAIL st_x1v_2 got %b exp 1", bus.x1_valid); else pass_cnt++;
        chk_cnt++; if (bus.x0_valid !== 1'b0) $display("FAIL st_x0v_2 got %b exp 0", bus.x0_valid); else pass_cnt++;
        send(1, 1, 8'h33);
        chk_cnt++; if (bus.x0 !== 8'h33 || bus.x0_valid !== 1'b1) $display("FAIL st_x0_33 got %h/%b exp 33/1", bus.x0, bus.x0_valid); else pass_cnt++;
        send(1, 0, 8'h44);
        chk_cnt++; if (bus.x1 !== 8'h44 || bus.x1_valid !== 1'b1) $display("FAIL st_x1_44 got %h/%b exp 44/1", bus.x1, bus.x1_valid); else pass_cnt++;
        send(0, 0, 8'h00);
        chk_cnt++; if (bus.x0_valid !== 1'b0 || bus.x1_valid !== 1'b0) $display("FAIL st_idle_v got %b%b exp 00", bus.x0_valid, bus.x1_valid); else pass_cnt++;
        chk_cnt++; if (bus.x0 !== 8'h33) $display("FAIL st_hold_x0 got %h exp 33", bus.x0); else pass_cnt++;
        chk_cnt++; if (bus.err_cnt !== 8'd0) $display("FAIL st_err got %0d exp 0", bus.err_cnt); else pass_cnt++;
    endtask

    task automatic test_hunt();
        do_reset();
        send(1, 0, 8'hAA);
        chk_cnt++; if (bus.x0_valid !== 1'b0 || bus.x1_valid !== 1'b0) $display("FAIL hunt_aa_v got %b%b exp 00", bus.x0_valid, bus.x1_valid); else pass_cnt++;
        send(1, 0, 8'hBB);
        chk_cnt++; if (bus.sync !== 1'b0) $display("FAIL hunt_sync got %b exp 0", bus.sync); else pass_cnt++;
        chk_cnt++; if (bus.err_cnt !== 8'd0) $display("FAIL hunt_err got %0d exp 0", bus.err_cnt); else pass_cnt++;
        chk_cnt++; if (bus.x1 !== 8'h00) $display("FAIL hunt_x1 got %h exp 00", bus.x1); else pass_cnt++;
        send(1, 1, 8'h01);
        chk_cnt++; if (bus.x0 !== 8'h01 || bus.sync !== 1'b1) $display("FAIL hunt_lock got %h/%b exp 01/1", bus.x0, bus.sync); else pass_cnt++;
    endtask

    task automatic test_lost_align();
        send(1, 0, 8'h02);
        chk_cnt++; if (bus.x1 !== 8'h02) $display("FAIL la_x1 got %h exp 02", bus.x1); else pass_cnt++;
        send(1, 0, 8'h55);
        chk_cnt++; if (bus.x1_valid !== 1'b0 || bus.x1 !== 8'h02) $display("FAIL la_drop got %h/%b exp 02/0", bus.x1, bus.x1_valid); else pass_cnt++;
        chk_cnt++; if (bus.sync !== 1'b0) $display("FAIL la_sync got %b exp 0", bus.sync); else pass_cnt++;
        chk_cnt++; if (bus.err_cnt !== 8'd1) $display("FAIL la_err got %0d exp 1", bus.err_cnt); else pass_cnt++;
        send(1, 1, 8'h66);
        chk_cnt++; if (bus.x0 !== 8'h66 || bus.sync !== 1'b1) $display("FAIL la_resync got %h/%b exp 66/1", bus.x0, bus.sync); else pass_cnt++;
    endtask

    task automatic test_short_frame();
        send(1, 1, 8'h77);
        chk_cnt++; if (bus.x0 !== 8'h77 || bus.x0_valid !== 1'b1) $display("FAIL sf_x0 got %h/%b exp 77/1", bus.x0, bus.x0_valid); else pass_cnt++;
        chk_cnt++; if (bus.x1 !== 8'h02) $display("FAIL sf_x1_hold got %h exp 02", bus.x1); else pass_cnt++;
        chk_cnt++; if (bus.err_cnt !== 8'd2) $display("FAIL sf_err got %0d exp 2", bus.err_cnt); else pass_cnt++;
        chk_cnt++; if (bus.sync !== 1'b1) $display("FAIL sf_sync got %b exp 1", bus.sync); else pass_cnt++;
        send(1, 0, 8'h88);
        chk_cnt++; if (bus.x1 !== 8'h88 || bus.x1_valid !== 1'b1) $display("FAIL sf_x1 got %h/%b exp 88/1", bus.x1, bus.x1_valid); else pass_cnt++;
    endtask

    task automatic test_gaps();
        do_reset();
        send(1, 1, 8'h11);
        chk_cnt++; if (bus.x0 !== 8'h11 || bus.x0_valid !== 1'b1) $display("FAIL gap_x0 got %h/%b exp 11/1", bus.x0, bus.x0_valid); else pass_cnt++;
        send(0, 1, 8'hEE);
        chk_cnt++; if (bus.x0_valid !== 1'b0 || bus.x0 !== 8'h11) $display("FAIL gap_idle1 got %h/%b exp 11/0", bus.x0, bus.x0_valid); else pass_cnt++;
        send(0, 0, 8'hEE);
        chk_cnt++; if (bus.x1_valid !== 1'b0 || bus.sync !== 1'b1) $display("FAIL gap_idle2 got %b/%b exp 0/1", bus.x1_valid, bus.sync); else pass_cnt++;
        send(1, 0, 8'h22);
        chk_cnt++; if (bus.x1 !== 8'h22 || bus.x1_valid !== 1'b1) $display("FAIL gap_x1 got %h/%b exp 22/1", bus.x1, bus.x1_valid); else pass_cnt++;
        send(0, 0, 8'h00);
        chk_cnt++; if (bus.x1_valid !== 1'b0) $display("FAIL gap_idle3 got %b exp 0", bus.x1_valid); else pass_cnt++;
        send(1, 1, 8'h33);
        chk_cnt++; if (bus.x0 !== 8'h33 || bus.x0_valid !== 1'b1) $display("FAIL gap_x0b got %h/%b exp 33/1", bus.x0, bus.x0_valid); else pass_cnt++;
        chk_cnt++; if (bus.err_cnt !== 8'd0) $display("FAIL gap_err got %0d exp 0", bus.err_cnt); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        send(1, 0, 8'h44);
        send(1, 1, 8'h45);
        #2 rst = 1'b1;
        #1;
        chk_cnt++; if (bus.x0 !== 8'h00 || bus.x1 !== 8'h00) $display("FAIL mr_x got %h/%h exp 00/00", bus.x0, bus.x1); else pass_cnt++;
        chk_cnt++; if (bus.x0_valid !== 1'b0 || bus.sync !== 1'b0) $display("FAIL mr_vs got %b/%b exp 0/0", bus.x0_valid, bus.sync); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        send(1, 1, 8'h5A);
        chk_cnt++; if (bus.x0 !== 8'h5A || bus.x0_valid !== 1'b1) $display("FAIL mr_first got %h/%b exp 5a/1", bus.x0, bus.x0_valid); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 11; i++) send(1, 1, 8'(i));
        chk_cnt++; if (bus.err_cnt !== 8'd10) $display("FAIL sat_10 got %0d exp 10", bus.err_cnt); else pass_cnt++;
        for (int i = 11; i < 256; i++) send(1, 1, 8'(i));
        chk_cnt++; if (bus.err_cnt !== 8'd255) $display("FAIL sat_255 got %0d exp 255", bus.err_cnt); else pass_cnt++;
        for (int i = 256; i < 301; i++) send(1, 1, 8'(i));
        chk_cnt++; if (bus.err_cnt !== 8'd255) $display("FAIL sat_300 got %0d exp 255", bus.err_cnt); else pass_cnt++;
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        do_reset();
        send(1, 1, 8'h10);
        chk_cnt++; if (bus.x0 !== 8'h10 || bus.x0_valid !== 1'b1) $display("FAIL par_x0 got %h/%b exp 10/1", bus.x0, bus.x0_valid); else pass_cnt++;
        send(1, 0, 8'h20, 1'b1);
        chk_cnt++; if (bus.x1 !== 8'h00 || bus.x1_valid !== 1'b0) $display("FAIL par_bad got %h/%b exp 00/0", bus.x1, bus.x1_valid); else pass_cnt++;
        chk_cnt++; if (bus.err_cnt !== 8'd1) $display("FAIL par_err got %0d exp 1", bus.err_cnt); else pass_cnt++;
        send(1, 1, 8'h30);
        chk_cnt++; if (bus.x0 !== 8'h30 || bus.x0_valid !== 1'b1) $display("FAIL par_next got %h/%b exp 30/1", bus.x0, bus.x0_valid); else pass_cnt++;
        chk_cnt++; if (bus.err_cnt !== 8'd1) $display("FAIL par_err2 got %0d exp 1", bus.err_cnt); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_hunt();
        test_lost_align();
        test_short_frame();
        test_gaps();
        test_mid_reset();
        test_saturation();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
